time_keeper: RTL and testbench
==============================

// Module: time_keeper
// PURPOSE
//  Real-time HH:MM:SS counter with two-button set mode. Produces binary sec/min/hour
//  for the 6-digit multiplexed seven-segment display stage that sits directly downstream.
//  Buttons are raw board inputs; this block synchronizes and debounces them.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency; 1 s tick = CLK_HZ cycles
//  DEB_CYCLES  500_000     cycles a button must be stable before it is accepted (10 ms)
// PORTS
//  clk       in   1  system clock
//  rst       in   1  reset, synchronous, active-high
//  btn_mode  in   1  raw mode button, active-high, asynchronous
//  btn_inc   in   1  raw increment button, active-high, asynchronous
//  sec       out  6  seconds 0..59
//  min       out  6  minutes 0..59
//  hour      out  5  hours 0..23
//  mode      out  2  0=RUN 1=SET_HOUR 2=SET_MIN (3=SET_ALM with ALARM_EN)
//  blink     out  1  2 Hz square wave in any SET state, 0 in RUN (display blanking hint)
// BEHAVIOUR
//  - Reset: sec=min=hour=0, mode=RUN, blink=0, prescaler=0, debouncers cleared.
//  - Per button: 2-FF synchronizer -> stability counter (DEB_CYCLES) -> debounced
//    level -> one-cycle press pulse on its 0->1 edge. Press pulse appears
//    2+DEB_CYCLES+1 cycles after a clean input edge. Bounces shorter than DEB_CYCLES are ignored.
//  - Prescaler counts 0..CLK_HZ-1 in RUN only; tick is 1 cycle at CLK_HZ-1.
//  - RUN: tick -> sec+1; sec 59->0 carries min+1; min 59->0 carries hour+1; hour 23->0.
//    23:59:59 + tick -> 00:00:00 in the same cycle.
//  - FSM on mode press: RUN->SET_HOUR->SET_MIN->RUN (with ALARM_EN: SET_MIN->SET_ALM->RUN).
//  - SET_HOUR: inc press -> hour+1, 23->0, no carry. SET_MIN: inc press -> min+1, 59->0,
//    no carry into hour. Prescaler held at 0 and sec frozen in all SET states.
//  - Leaving SET_MIN (or SET_ALM) to RUN: sec forced to 0, prescaler restarts at 0;
//    first tick follows exactly CLK_HZ cycles later.
//  - Same-cycle mode and inc presses: mode wins, inc discarded.
//  - Tick and mode press in the same RUN cycle: tick is applied, then state -> SET_HOUR.
//  - inc press in RUN: ignored (except alarm acknowledge, see below).
//  - blink: toggles every CLK_HZ/4 cycles from the entry into any SET state, starting at 1;
//    forced to 0 in RUN.
//  - rst mid-operation (any state, any button level) returns to reset values next cycle;
//    a button held through reset produces no press until released and pressed again.
//  - Outputs are registered; values change only on clk edges.
// CONFIGURATION
//  ALARM_EN defined:
//   - Adds state SET_ALM (mode=3), an alarm register (alm_hour 5b, alm_min 6b, reset 00:00),
//     and port  alarm  out  1.
//   - In SET_ALM, inc advances the alarm in 1-minute steps, 23:59 -> 00:00.
//     Ports hour/min show the alarm value while in SET_ALM.
//   - In RUN, alarm rises when hour:min:sec == alm_hour:alm_min:00 and stays high
//     for 60 ticks or until an inc press (acknowledge), whichever comes first.
//   - Entering any SET state clears alarm. Reset value of alarm = 0.
//  ALARM_EN undefined:
//   - No alarm port and no alarm logic; 3-state FSM; mode never equals 3.
// TESTING  (bench uses CLK_HZ=8, DEB_CYCLES=3)
//  - Reset: rst 1 cycle, then run 8*61 cycles -> after 61 ticks: 00:01:01, mode=0, blink=0.
//  - Wrap: set 23:59 via SET states, return to RUN (sec=0), run 60 ticks -> 00:00:00.
//  - Set: mode press, 5 inc presses -> hour=5; mode, 61 inc presses -> min=1 (no carry);
//    mode -> mode=0, sec=0.
//  - Debounce: btn_inc pulses 2 cycles high x4 in SET_HOUR -> hour unchanged; then
//    5-cycle high -> hour+1 exactly once.
//  - Collision: mode and inc rise in the same cycle in SET_HOUR -> mode=2, hour unchanged.
//  - ALARM_EN: alarm 00:01, RUN from 00:00:00 -> alarm=1 at 00:01:00; inc press -> alarm=0
//    next cycle. Without ALARM_EN: 3 mode presses return to mode=0.

Source files
------------

// File: rtl/time_keeper_if.sv
// Button inputs and display outputs of time_keeper.
// With ALARM_EN defined the interface also carries the alarm output.
interface time_keeper_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;
    logic       blink;
`ifdef ALARM_EN
    logic       alarm;

    modport master (
        output btn_mode, btn_inc,
        input  sec, min, hour, mode, blink, alarm
    );

    modport slave (
        input  btn_mode, btn_inc,
        output sec, min, hour, mode, blink, alarm
    );
`else
    modport master (
        output btn_mode, btn_inc,
        input  sec, min, hour, mode, blink
    );

    modport slave (
        input  btn_mode, btn_inc,
        output sec, min, hour, mode, blink
    );
`endif
endinterface

// File: rtl/time_keeper.sv
// HH:MM:SS real-time counter with debounced two-button set mode and blink hint.
// Optional feature macro ALARM_EN adds the SET_ALM state, alarm register and alarm output.
module time_keeper #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic         clk,
    input  logic         rst,
    time_keeper_if.slave bus
);

    localparam int unsigned PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned DW         = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned BLINK_HALF = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int unsigned BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

`ifdef ALARM_EN
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_ALM  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;
`endif

    // Button index 0 = mode, 1 = inc
    logic [1:0]         btn_raw;
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         level_q, level_d;
    logic [1:0]         press_q, press_d;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;

    logic               mode_pulse;
    logic               inc_pulse;
    logic               tick;

    state_t             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [5:0]         sec_q, sec_d;
    logic [5:0]         min_q, min_d;
    logic [4:0]         hour_q, hour_d;
    logic               blink_q, blink_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;

`ifdef ALARM_EN
    logic [4:0]         alm_hour_q, alm_hour_d;
    logic [5:0]         alm_min_q, alm_min_d;
    logic               alarm_q, alarm_d;
    logic [5:0]         alm_cnt_q, alm_cnt_d;
    logic [4:0]         disp_hour_q, disp_hour_d;
    logic [5:0]         disp_min_q, disp_min_d;
`endif

    assign btn_raw = {bus.btn_inc, bus.btn_mode};

    // Synchronizer and accepted level reset to "pressed": a button held through
    // reset then shows no rising edge until it is released and pressed again.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        for (int unsigned i = 0; i < 2; i++) begin
            deb_cnt_d[i] = '0;
            level_d[i]   = level_q[i];
            press_d[i]   = 1'b0;
            if (sync2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    level_d[i] = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign mode_pulse = press_q[0];
    assign inc_pulse  = press_q[1] & ~press_q[0];
    assign tick       = (state_q == RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
`ifdef ALARM_EN
        alm_hour_d = alm_hour_q;
        alm_min_d  = alm_min_q;
`endif
        case (state_q)
            RUN: begin
                if (tick) begin
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d  = '0;
                            hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
                if (mode_pulse) begin
                    state_d = SET_HOUR;
                end
            end
            SET_HOUR: begin
                if (mode_pulse) begin
                    state_d = SET_MIN;
                end else if (inc_pulse) begin
                    hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
                end
            end
            SET_MIN: begin
                if (mode_pulse) begin
`ifdef ALARM_EN
                    state_d = SET_ALM;
`else
                    state_d = RUN;
                    sec_d   = '0;
`endif
                end else if (inc_pulse) begin
                    min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
                end
            end
`ifdef ALARM_EN
            SET_ALM: begin
                if (mode_pulse) begin
                    state_d = RUN;
                    sec_d   = '0;
                end else if (inc_pulse) begin
                    if (alm_min_q == 6'd59) begin
                        alm_min_d  = '0;
                        alm_hour_d = (alm_hour_q == 5'd23) ? '0 : alm_hour_q + 5'd1;
                    end else begin
                        alm_min_d = alm_min_q + 6'd1;
                    end
                end
            end
`endif
            default: state_d = RUN;
        endcase
    end

    // Prescaler only runs while staying in RUN; any SET state parks it at 0
    always_comb begin
        presc_d = '0;
        if (state_q == RUN && state_d == RUN && !tick) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_comb begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q;
        if (state_d == RUN) begin
            blink_d = 1'b0;
            bcnt_d  = '0;
        end else if (state_d != state_q) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
        end else if (bcnt_q == BLINK_LAST) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
        end else begin
            bcnt_d = bcnt_q + BW'(1);
        end
    end

`ifdef ALARM_EN
    // Alarm fires on the tick that lands on alm_hour:alm_min:00
    always_comb begin
        alarm_d   = alarm_q;
        alm_cnt_d = alm_cnt_q;
        if (state_d != RUN) begin
            alarm_d   = 1'b0;
            alm_cnt_d = '0;
        end else if (state_q == RUN) begin
            if (alarm_q && inc_pulse) begin
                alarm_d   = 1'b0;
                alm_cnt_d = '0;
            end else if (tick) begin
                if (alarm_q) begin
                    if (alm_cnt_q == 6'd59) begin
                        alarm_d   = 1'b0;
                        alm_cnt_d = '0;
                    end else begin
                        alm_cnt_d = alm_cnt_q + 6'd1;
                    end
                end else if (hour_d == alm_hour_q && min_d == alm_min_q && sec_d == 6'd0) begin
                    alarm_d   = 1'b1;
                    alm_cnt_d = '0;
                end
            end
        end
        disp_hour_d = (state_d == SET_ALM) ? alm_hour_d : hour_d;
        disp_min_d  = (state_d == SET_ALM) ? alm_min_d  : min_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '1;
            press_q   <= '0;
            deb_cnt_q <= '0;
            state_q   <= RUN;
            presc_q   <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            blink_q   <= 1'b0;
            bcnt_q    <= '0;
`ifdef ALARM_EN
            alm_hour_q  <= '0;
            alm_min_q   <= '0;
            alarm_q     <= 1'b0;
            alm_cnt_q   <= '0;
            disp_hour_q <= '0;
            disp_min_q  <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            presc_q   <= presc_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            blink_q   <= blink_d;
            bcnt_q    <= bcnt_d;
`ifdef ALARM_EN
            alm_hour_q  <= alm_hour_d;
            alm_min_q   <= alm_min_d;
            alarm_q     <= alarm_d;
            alm_cnt_q   <= alm_cnt_d;
            disp_hour_q <= disp_hour_d;
            disp_min_q  <= disp_min_d;
`endif
        end
    end

    assign bus.sec   = sec_q;
    assign bus.mode  = state_q;
    assign bus.blink = blink_q;
`ifdef ALARM_EN
    assign bus.hour  = disp_hour_q;
    assign bus.min   = disp_min_q;
    assign bus.alarm = alarm_q;
`else
    assign bus.hour  = hour_q;
    assign bus.min   = min_q;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with CLK_HZ=8, DEB_CYCLES=3.
// A press reaches the FSM 6 clock edges after the input rises.
module tb_time_keeper;

    localparam int unsigned CLK_HZ = 8;
    localparam int unsigned DEB    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    time_keeper_if bus ();

    time_keeper #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // All tasks start and end at a negedge.
    task automatic do_reset();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    // Returns at the negedge right after the press takes effect, button released.
    task automatic press(input bit is_mode);
        if (is_mode) bus.btn_mode = 1'b1;
        else         bus.btn_inc  = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
    endtask

    task automatic tap(input bit is_mode);
        press(is_mode);
        settle();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== 17'd0)
            $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", bus.hour, bus.min, bus.sec);
        else n_pass++;
        n_checks++;
        if (bus.mode !== 2'd0 || bus.blink !== 1'b0)
            $display("FAIL reset_mode: mode=%0d blink=%0b expected 0/0", bus.mode, bus.blink);
        else n_pass++;
        repeat (7) @(negedge clk);
        n_checks++;
        if (bus.sec !== 6'd0) $display("FAIL tick_early: sec=%0d expected 0", bus.sec);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.sec !== 6'd1) $display("FAIL first_tick: sec=%0d expected 1", bus.sec);
        else n_pass++;
        repeat (8 * 60) @(negedge clk);
        n_checks++;
        if (bus.hour !== 5'd0 || bus.min !== 6'd1 || bus.sec !== 6'd1)
            $display("FAIL run_61: got %0d:%0d:%0d expected 0:1:1", bus.hour, bus.min, bus.sec);
        else n_pass++;
        n_checks++;
        if (bus.mode !== 2'd0 || bus.blink !== 1'b0)
            $display("FAIL run_mode: mode=%0d blink=%0b expected 0/0", bus.mode, bus.blink);
        else n_pass++;
    endtask

    task automatic test_blink();
        logic [4:0] seq;
        do_reset();
        settle();
        bus.btn_mode = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.mode !== 2'd0) $display("FAIL press_latency: mode=%0d expected 0", bus.mode);
        else n_pass++;
        seq = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.btn_mode = 1'b0;
            seq = {seq[3:0], bus.blink};
            if (k == 0) begin
                n_checks++;
                if (bus.mode !== 2'd1) $display("FAIL press_edge: mode=%0d expected 1", bus.mode);
                else n_pass++;
            end
        end
        n_checks++;
        if (seq !== 5'b11001) $display("FAIL blink_seq: got %b expected 11001", seq);
        else n_pass++;
        settle();
        tap(1'b1);
`ifdef ALARM_EN
        tap(1'b1);
`endif
        tap(1'b1);
        n_checks++;
        if (bus.mode !== 2'd0 || bus.blink !== 1'b0)
            $display("FAIL blink_run: mode=%0d blink=%0b expected 0/0", bus.mode, bus.blink);
        else n_pass++;
    endtask

    task automatic test_set();
        do_reset();
        settle();
        tap(1'b1);
        n_checks++;
        if (bus.mode !== 2'd1) $display("FAIL set_enter: mode=%0d expected 1", bus.mode);
        else n_pass++;
        repeat (5) tap(1'b0);
        n_checks++;
        if (bus.hour !== 5'd5) $display("FAIL set_hour: hour=%0d expected 5", bus.hour);
        else n_pass++;
        tap(1'b1);
        n_checks++;
        if (bus.mode !== 2'd2) $display("FAIL set_min_enter: mode=%0d expected 2", bus.mode);
        else n_pass++;
        repeat (61) tap(1'b0);
        n_checks++;
        if (bus.min !== 6'd1 || bus.hour !== 5'd5)
            $display("FAIL set_min_wrap: got %0d:%0d expected 5:1", bus.hour, bus.min);
        else n_pass++;
`ifdef ALARM_EN
        tap(1'b1);
`endif
        press(1'b1);
        n_checks++;
        if (bus.mode !== 2'd0 || bus.sec !== 6'd0 || bus.hour !== 5'd5 || bus.min !== 6'd1)
            $display("FAIL set_exit: mode=%0d time=%0d:%0d:%0d expected 0 5:1:0",
                     bus.mode, bus.hour, bus.min, bus.sec);
        else n_pass++;
        // Mode press lands on the second tick after leaving SET
        repeat (10) @(negedge clk);
        press(1'b1);
        n_checks++;
        if (bus.mode !== 2'd1 || bus.sec !== 6'd2)
            $display("FAIL tick_and_mode: mode=%0d sec=%0d expected 1/2", bus.mode, bus.sec);
        else n_pass++;
        settle();
        tap(1'b1);
`ifdef ALARM_EN
        tap(1'b1);
`endif
        tap(1'b1);
        tap(1'b0);
        n_checks++;
        if (bus.mode !== 2'd0 || bus.hour !== 5'd5 || bus.min !== 6'd1)
            $display("FAIL run_inc_ignored: mode=%0d time=%0d:%0d expected 0 5:1",
                     bus.mode, bus.hour, bus.min);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        settle();
        tap(1'b1);
        repeat (23) tap(1'b0);
        tap(1'b1);
        repeat (59) tap(1'b0);
        n_checks++;
        if (bus.hour !== 5'd23 || bus.min !== 6'd59)
            $display("FAIL wrap_setup: got %0d:%0d expected 23:59", bus.hour, bus.min);
        else n_pass++;
`ifdef ALARM_EN
        tap(1'b1);
`endif
        press(1'b1);
        repeat (479) @(negedge clk);
        n_checks++;
        if (bus.hour !== 5'd23 || bus.min !== 6'd59 || bus.sec !== 6'd59)
            $display("FAIL wrap_pre: got %0d:%0d:%0d expected 23:59:59", bus.hour, bus.min, bus.sec);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus.hour, bus.min, bus.sec} !== 17'd0)
            $display("FAIL wrap: got %0d:%0d:%0d expected 0:0:0", bus.hour, bus.min, bus.sec);
        else n_pass++;
    endtask

    task automatic test_debounce();
        do_reset();
        settle();
        tap(1'b1);
        for (int k = 0; k < 4; k++) begin
            bus.btn_inc = 1'b1;
            repeat (2) @(negedge clk);
            bus.btn_inc = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (bus.hour !== 5'd0) $display("FAIL bounce_ignored: hour=%0d expected 0", bus.hour);
        else n_pass++;
        bus.btn_inc = 1'b1;
        repeat (5) @(negedge clk);
        bus.btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (bus.hour !== 5'd1) $display("FAIL stable_press: hour=%0d expected 1", bus.hour);
        else n_pass++;
    endtask

    task automatic test_collision();
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        settle();
        n_checks++;
        if (bus.mode !== 2'd2 || bus.hour !== 5'd1)
            $display("FAIL collision: mode=%0d hour=%0d expected 2/1", bus.mode, bus.hour);
        else n_pass++;
    endtask

    task automatic test_mode_cycle();
        do_reset();
        settle();
        tap(1'b1);
        tap(1'b1);
        n_checks++;
        if (bus.mode !== 2'd2) $display("FAIL cycle_two: mode=%0d expected 2", bus.mode);
        else n_pass++;
`ifdef ALARM_EN
        tap(1'b1);
        n_checks++;
        if (bus.mode !== 2'd3) $display("FAIL cycle_alm: mode=%0d expected 3", bus.mode);
        else n_pass++;
`endif
        tap(1'b1);
        n_checks++;
        if (bus.mode !== 2'd0) $display("FAIL cycle_back: mode=%0d expected 0", bus.mode);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        settle();
        tap(1'b1);
        tap(1'b0);
        tap(1'b0);
        bus.btn_mode = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.mode !== 2'd0 || bus.hour !== 5'd0 || bus.blink !== 1'b0)
            $display("FAIL reset_mid: mode=%0d hour=%0d blink=%0b expected 0/0/0",
                     bus.mode, bus.hour, bus.blink);
        else n_pass++;
        repeat (20) @(negedge clk);
        n_checks++;
        if (bus.mode !== 2'd0) $display("FAIL held_through_reset: mode=%0d expected 0", bus.mode);
        else n_pass++;
        bus.btn_mode = 1'b0;
        settle();
        tap(1'b1);
        n_checks++;
        if (bus.mode !== 2'd1) $display("FAIL press_after_release: mode=%0d expected 1", bus.mode);
        else n_pass++;
    endtask

`ifdef ALARM_EN
    task automatic test_alarm();
        do_reset();
        settle();
        tap(1'b1);
        tap(1'b1);
        tap(1'b1);
        tap(1'b0);
        n_checks++;
        if (bus.mode !== 2'd3 || bus.hour !== 5'd0 || bus.min !== 6'd1)
            $display("FAIL alm_set: mode=%0d shows %0d:%0d expected 3 0:1", bus.mode, bus.hour, bus.min);
        else n_pass++;
        press(1'b1);
        repeat (479) @(negedge clk);
        n_checks++;
        if (bus.alarm !== 1'b0 || bus.min !== 6'd0 || bus.sec !== 6'd59)
            $display("FAIL alm_pre: alarm=%0b min=%0d sec=%0d expected 0/0/59", bus.alarm, bus.min, bus.sec);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.alarm !== 1'b1 || bus.min !== 6'd1 || bus.sec !== 6'd0)
            $display("FAIL alm_fire: alarm=%0b min=%0d sec=%0d expected 1/1/0", bus.alarm, bus.min, bus.sec);
        else n_pass++;
        press(1'b0);
        n_checks++;
        if (bus.alarm !== 1'b0) $display("FAIL alm_ack: alarm=%0b expected 0", bus.alarm);
        else n_pass++;
        settle();
    endtask
`endif

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        @(negedge clk);
        test_reset();
        test_blink();
        test_set();
        test_wrap();
        test_debounce();
        test_collision();
        test_mode_cycle();
        test_reset_mid();
`ifdef ALARM_EN
        test_alarm();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
